prog_lut: RTL and testbench

PROG_LUT -- requirements
Module: prog_lut

---
 rtl/prog_lut_pkg.sv | 17 +
 rtl/prog_lut_mem.sv | 74 +++++++
 rtl/prog_lut.sv | 105 ++++++++++
 tb/tb_prog_lut.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_lut_pkg.sv
// Shared definitions for the programmable lookup table.
// Contents:
//   DefIw   - default address width (table depth = 2**DefIw)
//   DefOw   - default entry width
//   state_e - sweep controller states: idle, sweeping, done pulse
package prog_lut_pkg;

    localparam int unsigned DefIw = 3;
    localparam int unsigned DefOw = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/prog_lut_mem.sv
// Flop-based table with one write port and one registered read port.
// A read and a write to the same address in the same cycle returns the
// new write data (write-through bypass).
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data - write port
//   rd_en/rd_addr        - read request, result registered one cycle later
//   out_valid            - one-cycle pulse per completed read
//   out_addr/out_data    - address and entry of the last completed read
module lut_mem
    import prog_lut_pkg::*;
#(
    parameter int unsigned    IW      = DefIw,
    parameter int unsigned    OW      = DefOw,
    parameter logic [OW-1:0]  RST_VAL = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [OW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_addr,
    output logic          out_valid,
    output logic [IW-1:0] out_addr,
    output logic [OW-1:0] out_data
);

    localparam int unsigned Depth = 2 ** IW;

    logic [OW-1:0] mem_q [Depth];
    logic [OW-1:0] rd_data_d;
    logic          out_valid_q;
    logic [IW-1:0] out_addr_q;
    logic [OW-1:0] out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Bypass so a same-cycle write is seen by the read.
    always_comb begin
        rd_data_d = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
    end

    // Address/data hold their last value when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_en;
            if (rd_en) begin
                out_addr_q <= rd_addr;
                out_data_q <= rd_data_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/prog_lut.sv
// Programmable lookup table with external lookups and a full-table sweep.
// External lookups are accepted when rd_ready is high (idle or done state);
// a sweep issues one internal lookup per cycle, addresses 0..2**IW-1 in
// order, through the same output path. sweep_done is high in the cycle the
// last swept entry is presented.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data     - table write, accepted in every state
//   rd_req/rd_addr/rd_ready   - external lookup request and acceptance
//   out_valid/out_addr/out_data - lookup result, latency 1
//   sweep_start               - start a dump of the whole table
//   sweep_busy, sweep_done    - sweep in progress, sweep finished pulse
module prog_lut
    import prog_lut_pkg::*;
#(
    parameter int unsigned    IW      = DefIw,
    parameter int unsigned    OW      = DefOw,
    parameter logic [OW-1:0]  RST_VAL = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [OW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [IW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_addr,
    output logic [OW-1:0] out_data,
    input  logic          sweep_start,
    output logic          sweep_busy,
    output logic          sweep_done
);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mem_rd_en;
    logic [IW-1:0] mem_rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (sweep_start) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                // Last index is issued this cycle; the counter never wraps.
                if (idx_q == '1) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    assign rd_ready   = (state_q != StSweep);
    assign sweep_busy = (state_q == StSweep);
    assign sweep_done = (state_q == StDone);

    // External requests while sweeping are dropped, not queued.
    assign mem_rd_en   = sweep_busy | (rd_req & rd_ready);
    assign mem_rd_addr = sweep_busy ? idx_q : rd_addr;

    lut_mem #(
        .IW      (IW),
        .OW      (OW),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (mem_rd_en),
        .rd_addr   (mem_rd_addr),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_prog_lut.sv
// Scoreboard bench for prog_lut: the driver predicts each result from a
// behavioural table model and queues it; the monitor checks DUT output.
module tb_prog_lut;

    localparam int IW    = 3;
    localparam int OW    = 2;
    localparam int DEPTH = 2 ** IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [OW-1:0] wr_data;
    logic          rd_req;
    logic [IW-1:0] rd_addr;
    logic          rd_ready;
    logic          out_valid;
    logic [IW-1:0] out_addr;
    logic [OW-1:0] out_data;
    logic          sweep_start;
    logic          sweep_busy;
    logic          sweep_done;

    always #5 clk = ~clk;

    prog_lut #(
        .IW      (IW),
        .OW      (OW),
        .RST_VAL (2'b11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
    );

    typedef struct {
        int addr;
        int data;
        int done;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   in_reset = 1'b1;

    // Reference model: table contents plus sweep progress.
    int   ref_mem [DEPTH];
    bit   sweeping;
    bit   done_cycle;
    int   sweep_idx;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 3;
        sweeping   = 1'b0;
        done_cycle = 1'b0;
        sweep_idx  = 0;
        q.delete();
    endtask

    // One clock cycle of stimulus; expected results are queued here.
    task automatic step(input bit we, input int wa, input int wd,
                        input bit rq, input int ra, input bit ss);
        exp_t e;
        int   a;
        @(negedge clk);
        wr_en       = we;
        wr_addr     = IW'(wa);
        wr_data     = OW'(wd);
        rd_req      = rq;
        rd_addr     = IW'(ra);
        sweep_start = ss;
        check("rd_ready", int'(rd_ready), int'(!sweeping));
        check("sweep_busy", int'(sweep_busy), int'(sweeping));
        if (sweeping) begin
            a = sweep_idx;
            e.addr = a;
            e.data = (we && wa == a) ? wd : ref_mem[a];
            e.done = (a == DEPTH - 1) ? 1 : 0;
            q.push_back(e);
            if (a == DEPTH - 1) begin
                sweeping   = 1'b0;
                done_cycle = 1'b1;
            end else begin
                sweep_idx = a + 1;
            end
        end else begin
            if (rq) begin
                e.addr = ra;
                e.data = (we && wa == ra) ? wd : ref_mem[ra];
                e.done = 0;
                q.push_back(e);
            end
            if (done_cycle) begin
                done_cycle = 1'b0;
            end else if (ss) begin
                sweeping  = 1'b1;
                sweep_idx = 0;
            end
        end
        if (we) ref_mem[wa] = wd;
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0; sweep_start = 0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        in_reset = 1'b1;
        rst = 1'b1;
        idle_inputs();
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_addr", int'(out_addr), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_sweep_busy", int'(sweep_busy), 0);
        check("rst_sweep_done", int'(sweep_done), 0);
        check("rst_rd_ready", int'(rd_ready), 1);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_reset = 1'b0;
    endtask

    // Monitor: each expected entry is due exactly one edge after issue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", int'(out_valid), 0);
                    check("sweep_done_idle", int'(sweep_done), 0);
                end else begin
                    e = q.pop_front();
                    check("out_valid", int'(out_valid), 1);
                    if (out_valid) begin
                        check("out_addr", int'(out_addr), e.addr);
                        check("out_data", int'(out_data), e.data);
                    end
                    check("sweep_done", int'(sweep_done), e.done);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        do_reset();

        // Reset contents: every entry reads back all-ones.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, 0);

        // Program a few entries, then look one up.
        step(1, 1, 1, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0);

        // Full dump; rd_req and repeated sweep_start while busy are ignored.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Same-cycle write and read of one address.
        step(1, 5, 2, 1, 5, 0);
        step(0, 0, 0, 1, 5, 0);

        // Write to a not-yet-swept address during a dump.
        step(0, 0, 0, 0, 0, 1);
        step(1, 6, 1, 0, 0, 0);
        for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Reset in the 4th sweep cycle aborts the dump and restores the table.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i, 0);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 11) == 0));
            end
        end

        for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 0, 0, 0, 0);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
